// File: rtl/alu_arbiter.sv
// alu_arbiter_pkg: operation encoding shared by the arbiter, its requesters
// and the external ALU.
//
// alu_arbiter: two-requester round-robin front end for one shared
// combinational ALU. A request is accepted in IDLE, and its operands are
// registered. The ALU is evaluated for exactly one cycle (EXEC). Its result
// is then held in RESP until the owning requester consumes it.
//
// Ports
//   clk_i, reset_ni             clock, asynchronous active-low reset
//   rN_req_valid_i/ready_o      request handshake per requester (N = 0, 1)
//   rN_a_i, rN_b_i, rN_op_i     operands and operation per requester
//   rN_rsp_valid_o/ready_i      response handshake per requester
//   rsp_y_o, rsp_flags_o        registered result and flags (shared)
//   alu_a_o, alu_b_o, alu_op_o  registered operands to the external ALU
//   alu_y_i, alu_flags_i        combinational result from the external ALU

package alu_arbiter_pkg;
  typedef enum logic [2:0] {
    AddOp,
    SubOp,
    AndOp,
    OrOp,
    XorOp,
    SltOp,
    SllOp,
    SrlOp
  } ALU_Ops;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_SIZE  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,

  input  logic                  r0_req_valid_i,
  output logic                  r0_req_ready_o,
  input  logic [DATA_WIDTH-1:0] r0_a_i,
  input  logic [DATA_WIDTH-1:0] r0_b_i,
  input  ALU_Ops                r0_op_i,
  output logic                  r0_rsp_valid_o,
  input  logic                  r0_rsp_ready_i,

  input  logic                  r1_req_valid_i,
  output logic                  r1_req_ready_o,
  input  logic [DATA_WIDTH-1:0] r1_a_i,
  input  logic [DATA_WIDTH-1:0] r1_b_i,
  input  ALU_Ops                r1_op_i,
  output logic                  r1_rsp_valid_o,
  input  logic                  r1_rsp_ready_i,

  output logic [DATA_WIDTH-1:0] rsp_y_o,
  output logic [FLAG_SIZE-1:0]  rsp_flags_o,

  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output ALU_Ops                alu_op_o,
  input  logic [DATA_WIDTH-1:0] alu_y_i,
  input  logic [FLAG_SIZE-1:0]  alu_flags_i
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                state_q, state_d;
  logic                  owner_q;   // 0: r0 owns the in-flight op, 1: r1
  logic                  last_q;    // requester served by the most recent grant
  logic [DATA_WIDTH-1:0] a_q, b_q;
  ALU_Ops                op_q;
  logic [DATA_WIDTH-1:0] y_q;
  logic [FLAG_SIZE-1:0]  flags_q;

  logic grant_r1;
  logic accept;
  logic owner_rsp_ready;

  // r1 wins when it is the only requester, or on a tie when r0 was served last.
  assign grant_r1        = r1_req_valid_i && (!r0_req_valid_i || !last_q);
  assign accept          = (state_q == IDLE) && (r0_req_valid_i || r1_req_valid_i);
  assign owner_rsp_ready = owner_q ? r1_rsp_ready_i : r0_rsp_ready_i;

  // NOTE: every signal written in an always_comb gets a default value first.
  // That way no path leaves it unassigned, and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from pre-edge values, with no ordering races.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers load only on accept and so stay stable through
  // EXEC and RESP. Late changes on the request inputs cannot reach the ALU.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= AddOp;
      owner_q <= 1'b0;
      last_q  <= 1'b1;   // r0 wins the first tie after reset
    end else if (accept) begin
      a_q     <= grant_r1 ? r1_a_i  : r0_a_i;
      b_q     <= grant_r1 ? r1_b_i  : r0_b_i;
      op_q    <= grant_r1 ? r1_op_i : r0_op_i;
      owner_q <= grant_r1;
      last_q  <= grant_r1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      y_q     <= '0;
      flags_q <= '0;
    end else if (state_q == EXEC) begin
      y_q     <= alu_y_i;
      flags_q <= alu_flags_i;
    end
  end

  assign r0_req_ready_o = (state_q == IDLE) && r0_req_valid_i && !grant_r1;
  assign r1_req_ready_o = (state_q == IDLE) && grant_r1;

  assign r0_rsp_valid_o = (state_q == RESP) && !owner_q;
  assign r1_rsp_valid_o = (state_q == RESP) &&  owner_q;

  assign rsp_y_o     = y_q;
  assign rsp_flags_o = flags_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. The bench provides the external ALU
// as a small behavioural model. It runs a vector table of single operations
// and hand-written multi-cycle sequences: tie, backpressure, operand
// isolation, and reset mid-response. It finishes with a round-robin stream
// that is checked against a scoreboard.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int FW = 4;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          r0_req_valid_i, r1_req_valid_i;
  logic          r0_req_ready_o, r1_req_ready_o;
  logic [DW-1:0] r0_a_i, r0_b_i, r1_a_i, r1_b_i;
  ALU_Ops        r0_op_i, r1_op_i;
  logic          r0_rsp_valid_o, r1_rsp_valid_o;
  logic          r0_rsp_ready_i, r1_rsp_ready_i;
  logic [DW-1:0] rsp_y_o;
  logic [FW-1:0] rsp_flags_o;
  logic [DW-1:0] alu_a_o, alu_b_o;
  ALU_Ops        alu_op_o;
  logic [DW-1:0] alu_y_i;
  logic [FW-1:0] alu_flags_i;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .FLAG_SIZE(FW)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .r0_req_valid_i(r0_req_valid_i),
    .r0_req_ready_o(r0_req_ready_o),
    .r0_a_i        (r0_a_i),
    .r0_b_i        (r0_b_i),
    .r0_op_i       (r0_op_i),
    .r0_rsp_valid_o(r0_rsp_valid_o),
    .r0_rsp_ready_i(r0_rsp_ready_i),
    .r1_req_valid_i(r1_req_valid_i),
    .r1_req_ready_o(r1_req_ready_o),
    .r1_a_i        (r1_a_i),
    .r1_b_i        (r1_b_i),
    .r1_op_i       (r1_op_i),
    .r1_rsp_valid_o(r1_rsp_valid_o),
    .r1_rsp_ready_i(r1_rsp_ready_i),
    .rsp_y_o       (rsp_y_o),
    .rsp_flags_o   (rsp_flags_o),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_op_o      (alu_op_o),
    .alu_y_i       (alu_y_i),
    .alu_flags_i   (alu_flags_i)
  );

  always #5 clk_i = ~clk_i;

  // External ALU: returns {flags(VNCZ), y}.
  function automatic logic [FW+DW-1:0] alu_model(input logic [DW-1:0] a, b, input ALU_Ops op);
    logic [DW:0]   wide;
    logic [DW-1:0] y;
    logic          v, c;
    wide = '0; y = '0; v = 1'b0; c = 1'b0;
    case (op)
      AddOp: begin
        wide = {1'b0, a} + {1'b0, b};
        y = wide[DW-1:0]; c = wide[DW];
        v = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
      SubOp: begin
        wide = {1'b0, a} + {1'b0, ~b} + 1;
        y = wide[DW-1:0]; c = wide[DW];
        v = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
      AndOp: y = a & b;
      OrOp:  y = a | b;
      XorOp: y = a ^ b;
      SltOp: y = ($signed(a) < $signed(b)) ? 1 : 0;
      SllOp: y = a << b[4:0];
      SrlOp: y = a >> b[4:0];
      default: y = '0;
    endcase
    return {v, y[DW-1], c, (y == 0), y};
  endfunction

  always_comb {alu_flags_i, alu_y_i} = alu_model(alu_a_o, alu_b_o, alu_op_o);

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input bit r, input bit v, input logic [DW-1:0] a, b, input ALU_Ops op);
    if (r) begin
      r1_req_valid_i = v; r1_a_i = a; r1_b_i = b; r1_op_i = op;
    end else begin
      r0_req_valid_i = v; r0_a_i = a; r0_b_i = b; r0_op_i = op;
    end
  endtask

  // One isolated operation with rsp_ready held high. It starts and ends in
  // IDLE, and checks accept in cycle T, no response in T+1, and the response
  // in T+2.
  task automatic single_op(input bit r, input logic [DW-1:0] a, b, input ALU_Ops op,
                           input logic [DW-1:0] ey, input logic [FW-1:0] ef);
    @(posedge clk_i); #1;
    r0_rsp_ready_i = 1'b1; r1_rsp_ready_i = 1'b1;
    drive_req(r, 1'b1, a, b, op);
    @(negedge clk_i);
    check("req_ready_owner", r ? r1_req_ready_o : r0_req_ready_o, 1);
    check("req_ready_other", r ? r0_req_ready_o : r1_req_ready_o, 0);
    @(posedge clk_i); #1;
    drive_req(r, 1'b0, '0, '0, AddOp);
    @(negedge clk_i);
    check("rsp_valid_exec", {r1_rsp_valid_o, r0_rsp_valid_o}, 0);
    @(negedge clk_i);
    check("rsp_valid_owner", r ? r1_rsp_valid_o : r0_rsp_valid_o, 1);
    check("rsp_valid_other", r ? r0_rsp_valid_o : r1_rsp_valid_o, 0);
    check("rsp_y", rsp_y_o, ey);
    check("rsp_flags", rsp_flags_o, ef);
    @(posedge clk_i); #1;
    check("rsp_valid_after_hs", {r1_rsp_valid_o, r0_rsp_valid_o}, 0);
  endtask

  typedef struct {
    bit            r;
    ALU_Ops        op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] y;
    logic [FW-1:0] f;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit            g, last_g, have_last, exp_owner, acc0, acc1;
    logic [FW+DW-1:0] exp;
    int            done, cyc;

    vecs[0] = '{0, AddOp, 32'h5,        32'h3,        32'h8,        4'b0000};
    vecs[1] = '{1, AddOp, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0011};
    vecs[2] = '{0, AddOp, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1100};
    vecs[3] = '{1, SubOp, 32'h5,        32'h5,        32'h0,        4'b0011};
    vecs[4] = '{0, OrOp,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 4'b0000};
    vecs[5] = '{1, XorOp, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'b0100};
    vecs[6] = '{0, SllOp, 32'h1,        32'd31,       32'h80000000, 4'b0100};
    vecs[7] = '{1, SrlOp, 32'h80000000, 32'd4,        32'h08000000, 4'b0000};
    vecs[8] = '{0, SltOp, 32'h1,        32'hFFFFFFFF, 32'h0,        4'b0001};

    reset_ni = 1'b0;
    r0_rsp_ready_i = 1'b0; r1_rsp_ready_i = 1'b0;
    drive_req(0, 1'b0, '0, '0, AddOp);
    drive_req(1, 1'b0, '0, '0, AddOp);

    // Reset state
    #12;
    check("rst_req_ready", {r1_req_ready_o, r0_req_ready_o}, 0);
    check("rst_rsp_valid", {r1_rsp_valid_o, r0_rsp_valid_o}, 0);
    check("rst_rsp_y", rsp_y_o, 0);
    check("rst_rsp_flags", rsp_flags_o, 0);
    check("rst_alu_a", alu_a_o, 0);
    check("rst_alu_op", 32'(alu_op_o), 32'(AddOp));
    #10 reset_ni = 1'b1;

    // Vector table of isolated operations
    for (int i = 0; i < 9; i++)
      single_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].y, vecs[i].f);

    // Tie after reset: r0 first, then r1, and the third tie goes to r0
    @(posedge clk_i); #1 reset_ni = 1'b0;
    #2 reset_ni = 1'b1;
    @(posedge clk_i); #1;
    r0_rsp_ready_i = 1'b1; r1_rsp_ready_i = 1'b1;
    drive_req(0, 1'b1, 32'd3, 32'd5, SubOp);
    drive_req(1, 1'b1, 32'hF0, 32'h3C, AndOp);
    @(negedge clk_i);
    check("tie1_r0_ready", r0_req_ready_o, 1);
    check("tie1_r1_ready", r1_req_ready_o, 0);
    @(posedge clk_i); #1 drive_req(0, 1'b0, '0, '0, AddOp);
    @(negedge clk_i);
    check("tie1_exec_r1_ready", r1_req_ready_o, 0);
    @(negedge clk_i);
    check("tie1_rsp_valid", r0_rsp_valid_o, 1);
    check("tie1_y", rsp_y_o, 32'hFFFFFFFE);
    check("tie1_flags", rsp_flags_o, 4'b0100);
    check("tie1_resp_r1_ready", r1_req_ready_o, 0);
    @(negedge clk_i);
    check("tie2_r1_ready", r1_req_ready_o, 1);
    @(posedge clk_i); #1 drive_req(1, 1'b0, '0, '0, AddOp);
    @(negedge clk_i); @(negedge clk_i);
    check("tie2_rsp_valid", r1_rsp_valid_o, 1);
    check("tie2_y", rsp_y_o, 32'h30);
    check("tie2_flags", rsp_flags_o, 4'b0000);
    @(posedge clk_i); #1;
    drive_req(0, 1'b1, 32'd1, 32'd1, AddOp);
    drive_req(1, 1'b1, 32'd2, 32'd2, AddOp);
    @(negedge clk_i);
    check("tie3_r0_ready", r0_req_ready_o, 1);
    check("tie3_r1_ready", r1_req_ready_o, 0);
    @(posedge clk_i); #1;
    drive_req(0, 1'b0, '0, '0, AddOp);
    drive_req(1, 1'b0, '0, '0, AddOp);
    repeat (3) @(posedge clk_i);

    // Backpressure on r1, with r0 waiting and a non-owner rsp_ready high
    #1;
    r0_rsp_ready_i = 1'b1; r1_rsp_ready_i = 1'b0;
    drive_req(1, 1'b1, 32'hFFFFFFFF, 32'h1, SltOp);
    @(negedge clk_i);
    check("bp_r1_ready", r1_req_ready_o, 1);
    @(posedge clk_i); #1;
    drive_req(1, 1'b0, '0, '0, AddOp);
    drive_req(0, 1'b1, 32'd1, 32'd1, AddOp);
    @(negedge clk_i);
    check("bp_exec_r0_ready", r0_req_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("bp_r1_rsp_valid", r1_rsp_valid_o, 1);
      check("bp_r0_rsp_valid", r0_rsp_valid_o, 0);
      check("bp_y", rsp_y_o, 32'h1);
      check("bp_r0_ready", r0_req_ready_o, 0);
    end
    @(posedge clk_i); #1 r1_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_hs_valid", r1_rsp_valid_o, 1);
    @(negedge clk_i);
    check("bp_after_r1_valid", r1_rsp_valid_o, 0);
    check("bp_after_r0_ready", r0_req_ready_o, 1);
    @(posedge clk_i); #1 drive_req(0, 1'b0, '0, '0, AddOp);
    @(negedge clk_i); @(negedge clk_i);
    check("bp_r0_y", rsp_y_o, 32'h2);

    // Operand isolation: request inputs change after accept
    @(posedge clk_i); #1;
    drive_req(0, 1'b1, 32'd10, 32'd20, AddOp);
    @(posedge clk_i); #1;
    drive_req(0, 1'b0, 32'd999, 32'd7, SubOp);
    @(negedge clk_i);
    check("iso_alu_a", alu_a_o, 32'd10);
    check("iso_alu_op", 32'(alu_op_o), 32'(AddOp));
    @(negedge clk_i);
    check("iso_y", rsp_y_o, 32'd30);

    // Reset while in RESP, then the first accept after release
    @(posedge clk_i); #1;
    r0_rsp_ready_i = 1'b0;
    drive_req(0, 1'b1, 32'hFF, 32'h0F, XorOp);
    @(posedge clk_i); #1 drive_req(0, 1'b0, '0, '0, AddOp);
    @(negedge clk_i); @(negedge clk_i);
    check("rr_pre_valid", r0_rsp_valid_o, 1);
    check("rr_pre_y", rsp_y_o, 32'hF0);
    #2 reset_ni = 1'b0;
    #1;
    check("rst_mid_valid", r0_rsp_valid_o, 0);
    check("rst_mid_y", rsp_y_o, 0);
    check("rst_mid_alu_a", alu_a_o, 0);
    @(negedge clk_i) reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_no_rsp", {r1_rsp_valid_o, r0_rsp_valid_o}, 0);
    end
    single_op(1, 32'd2, 32'd2, AddOp, 32'd4, 4'b0000);

    // Round-robin stream with both requesters always valid
    @(posedge clk_i); #1;
    drive_req(0, 1'b1, $urandom, $urandom, ALU_Ops'($urandom_range(0, 7)));
    drive_req(1, 1'b1, $urandom, $urandom, ALU_Ops'($urandom_range(0, 7)));
    r0_rsp_ready_i = 1'b1; r1_rsp_ready_i = 1'b1;
    done = 0; cyc = 0; have_last = 0; last_g = 0; exp_owner = 0; exp = '0;
    while (done < 1000 && cyc < 20000) begin
      @(negedge clk_i);
      cyc++;
      acc0 = 0; acc1 = 0;
      if (r0_req_ready_o || r1_req_ready_o) begin
        g = r1_req_ready_o;
        check("rr_one_grant", r0_req_ready_o & r1_req_ready_o, 0);
        if (have_last) check("rr_alternate", g, !last_g);
        last_g = g; have_last = 1; exp_owner = g;
        exp = g ? alu_model(r1_a_i, r1_b_i, r1_op_i) : alu_model(r0_a_i, r0_b_i, r0_op_i);
        acc0 = !g; acc1 = g;
      end
      if ((r0_rsp_valid_o && r0_rsp_ready_i) || (r1_rsp_valid_o && r1_rsp_ready_i)) begin
        check("rr_owner", r1_rsp_valid_o, exp_owner);
        check("rr_y", rsp_y_o, exp[DW-1:0]);
        check("rr_flags", rsp_flags_o, exp[FW+DW-1:DW]);
        done++;
      end
      @(posedge clk_i); #1;
      if (acc0) drive_req(0, 1'b1, $urandom, $urandom, ALU_Ops'($urandom_range(0, 7)));
      if (acc1) drive_req(1, 1'b1, $urandom, $urandom, ALU_Ops'($urandom_range(0, 7)));
      r0_rsp_ready_i = ($urandom_range(0, 3) != 0);
      r1_rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    check("rr_ops_done", done, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of operands and result.
REQ-002 SHALL have parameter FLAG_SIZE, default 4, width of ALU flags (VNCZ, bit 3..0).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports r0_req_valid_i / r1_req_valid_i  input  1  requester has an operation pending.
REQ-006 SHALL have ports r0_req_ready_o / r1_req_ready_o  output  1  arbiter accepts the request this cycle.
REQ-007 SHALL have ports r0_a_i, r0_b_i, r1_a_i, r1_b_i  input  DATA_WIDTH  operands per requester.
REQ-008 SHALL have ports r0_op_i / r1_op_i  input  ALU_Ops  operation per requester.
REQ-009 SHALL have ports r0_rsp_valid_o / r1_rsp_valid_o  output  1  result available for that requester.
REQ-010 SHALL have ports r0_rsp_ready_i / r1_rsp_ready_i  input  1  requester consumes result.
REQ-011 SHALL have port rsp_y_o  output  DATA_WIDTH  registered result (shared by both requesters).
REQ-012 SHALL have port rsp_flags_o  output  FLAG_SIZE  registered flags.
REQ-013 SHALL have ports alu_a_o, alu_b_o  output  DATA_WIDTH  and alu_op_o  output  ALU_Ops  drive the shared combinational ALU.
REQ-014 SHALL have ports alu_y_i  input  DATA_WIDTH  and alu_flags_i  input  FLAG_SIZE  from the shared ALU.

Function
REQ-015 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-016 IDLE: if any req_valid high, grant exactly one requester; assert only its req_ready (combinational from state, valids, last-grant pointer); both req_ready low outside IDLE.
REQ-017 Arbitration: single valid wins; both valid -> requester not served by the last grant wins (round-robin); pointer updates only on accept.
REQ-018 On accept edge: capture granted a, b, op into operand registers, record owner, go EXEC.
REQ-019 alu_a_o, alu_b_o, alu_op_o SHALL always be driven from operand registers (no combinational path from r*_a_i/b_i/op_i to ALU).
REQ-020 EXEC lasts exactly one cycle; at its closing edge capture alu_y_i, alu_flags_i into rsp_y_o, rsp_flags_o; go RESP.
REQ-021 RESP: assert rsp_valid of owner only; rsp_y_o/rsp_flags_o/operand registers hold stable until handshake.
REQ-022 RESP with owner rsp_ready high: handshake at that edge; go IDLE; rsp_valid low next cycle.
REQ-023 Latency: accept in cycle T -> rsp_valid high in cycle T+2 (rsp_ready tied high: new accept earliest cycle T+3 for 3-cycle throughput).
REQ-024 Non-owner rsp_ready ignored; req_valid changes during EXEC/RESP ignored (requesters hold valid until ready).
REQ-025 Owner rsp_ready high in IDLE/EXEC SHALL have no effect.
REQ-026 Results SHALL be passed unmodified; no arithmetic in this block; width equals DATA_WIDTH, no truncation or extension.

Reset
REQ-027 reset_ni low SHALL immediately force: state IDLE, all req_ready/rsp_valid low, rsp_y_o = 0, rsp_flags_o = 0, operand registers = 0, alu_op_o = AddOp, last-grant pointer = r1 (so r0 wins first tie).
REQ-028 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight operation; no rsp_valid after release.
REQ-029 After reset release, first accept possible in first cycle with a valid request.

Verification
REQ-030 Single op: r0 valid, a=5, b=3, op=AddOp, rsp_ready=1 -> r0_req_ready in cycle 0, r0_rsp_valid cycle 2, rsp_y_o=8, flags=0000, r1 outputs low throughout.
REQ-031 Tie: both valid after reset, r0 SubOp 3-5, r1 AndOp 0xF0&0x3C -> r0 served first (y=0xFFFFFFFE, N=1), then r1 (y=0x30); third tie goes to r0.
REQ-032 Backpressure: r1 SltOp a=0xFFFFFFFF b=1, rsp_ready low 4 cycles -> r1_rsp_valid high 4+ cycles, rsp_y_o=1 stable; r0 valid meanwhile not accepted until after handshake.
REQ-033 Operand isolation: change r0_a_i after accept -> alu_a_o and result unchanged.
REQ-034 Reset during RESP: reset_ni low mid-cycle -> rsp_valid and rsp_y_o drop to 0 without a clock edge; no response after release.
REQ-035 Random both-valid streams 1000 ops vs reference model: every result correct, no starvation (gap between grants to a waiting requester at most one other operation).
